// File: rtl/gps_pkg.sv
// Shared constants and arbiter state encoding for the GPS sentence arbiter.
package gps_pkg;

   localparam int BYTE_W = 8;

   localparam logic [BYTE_W-1:0] CH_DOLLAR = 8'h24;
   localparam logic [BYTE_W-1:0] CH_LF     = 8'h0A;
   localparam logic [BYTE_W-1:0] CH_SEP    = 8'h2C;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOCK  = 2'd1,
      S_ABORT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational N-way round-robin picker: first requester at or after ptr wins.
module rr_picker #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] grant,
   output logic                 valid
);

   localparam int OW = $clog2(N);

   int idx;

   // Walk from farthest to nearest so the closest requester overwrites last.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (req[idx]) begin
            grant = OW'(idx);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gps_sentence_arbiter.sv
// Sentence-level round-robin arbiter sharing one NMEA parser among N byte sources.
// Optional per-channel dropped-sentence counters: define GPS_ARB_DROP_COUNT_EN.
module gps_sentence_arbiter
   import gps_pkg::*;
#(
   parameter int B       = BYTE_W,
   parameter int N       = 2,
   parameter int MaxLen  = 82,
   parameter int Timeout = 100000
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [N-1:0]         load_in,
   input  logic [N*B-1:0]       data_in,
   output logic                 load_out,
   output logic [B-1:0]         data_out,
   output logic [$clog2(N)-1:0] owner,
   output logic                 busy,
   output logic                 abort,
   output arb_state_t           state
`ifdef GPS_ARB_DROP_COUNT_EN
   ,
   output logic [N*16-1:0]      drop_count
`endif
);

   localparam int OW = $clog2(N);
   localparam int LW = $clog2(MaxLen + 1);
   localparam int GW = $clog2(Timeout + 1);

   logic [N-1:0]  req;
   logic [OW-1:0] grant;
   logic          grant_valid;
   logic [OW-1:0] rr;
   logic [LW-1:0] len;
   logic [GW-1:0] gap;
   logic [B-1:0]  own_byte;
   logic          own_load;

   always_comb begin
      req = '0;
      for (int i = 0; i < N; i++) begin
         req[i] = load_in[i] && (data_in[i*B +: B] == B'(CH_DOLLAR));
      end
   end

   assign own_byte = data_in[owner*B +: B];
   assign own_load = load_in[owner];

   rr_picker #(.N(N)) u_picker (
      .req   (req),
      .ptr   (rr),
      .grant (grant),
      .valid (grant_valid)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         owner    <= '0;
         rr       <= '0;
         len      <= '0;
         gap      <= '0;
         load_out <= 1'b0;
         data_out <= '0;
         busy     <= 1'b0;
         abort    <= 1'b0;
      end else begin
         load_out <= 1'b0;
         abort    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_valid) begin
                  state    <= S_LOCK;
                  owner    <= grant;
                  rr       <= (grant == OW'(N - 1)) ? '0 : grant + OW'(1);
                  len      <= LW'(1);
                  gap      <= '0;
                  load_out <= 1'b1;
                  data_out <= data_in[grant*B +: B];
                  busy     <= 1'b1;
               end else begin
                  busy <= 1'b0;
               end
            end
            S_LOCK: begin
               if (own_load) begin
                  gap <= '0;
                  if (own_byte == B'(CH_DOLLAR)) begin
                     // Resync: the owner restarted its sentence.
                     load_out <= 1'b1;
                     data_out <= own_byte;
                     len      <= LW'(1);
                  end else if (len == LW'(MaxLen)) begin
                     state <= S_ABORT;
                     abort <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     load_out <= 1'b1;
                     data_out <= own_byte;
                     len      <= len + LW'(1);
                     if (own_byte == B'(CH_LF)) state <= S_IDLE;
                  end
               end else if (gap == GW'(Timeout)) begin
                  state <= S_ABORT;
                  abort <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  gap <= gap + GW'(1);
               end
            end
            S_ABORT: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef GPS_ARB_DROP_COUNT_EN
   logic [N-1:0] drop_vec;

   // A '$' is a dropped sentence unless it is the one being granted or the owner's resync.
   always_comb begin
      drop_vec = '0;
      for (int i = 0; i < N; i++) begin
         case (state)
            S_IDLE:  drop_vec[i] = req[i] && !(grant_valid && (grant == OW'(i)));
            S_LOCK:  drop_vec[i] = req[i] && (owner != OW'(i));
            default: drop_vec[i] = req[i];
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         drop_count <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (drop_vec[i] && (drop_count[i*16 +: 16] != 16'hFFFF)) begin
               drop_count[i*16 +: 16] <= drop_count[i*16 +: 16] + 16'd1;
            end
         end
      end
   end
`endif

endmodule
